// File: rtl/yscaler_pkg.sv
// yscaler_pkg: shared constants and state encoding
// for the vertical scaler line scheduler.
package yscaler_pkg;

  localparam int DIM_W = 12;
  localparam int NBUF  = 2;
  localparam int SEL_W = (NBUF > 1) ? $clog2(NBUF) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ADVANCE,
    DRAIN
  } state_e;

endpackage

// File: rtl/yscaler_dda.sv
// yscaler_dda: nearest-neighbour source-row tracker,
// one subtract step per cycle while advancing.
module yscaler_dda #(
  parameter int DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add,
  input  logic             step,
  input  logic [DIM_W:0]   ori_h,
  input  logic [DIM_W:0]   scale_h,
  output logic [DIM_W:0]   src_row,
  output logic             advance_busy
);

  logic [DIM_W:0] err;

  assign advance_busy = (err >= scale_h);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= '0;
      src_row <= '0;
    end else if (clr) begin
      err     <= '0;
      src_row <= '0;
    end else if (add) begin
      err <= err + ori_h;
    end else if (step && advance_busy) begin
      err     <= err - scale_h;
      src_row <= src_row + (DIM_W+1)'(1);
    end
  end

endmodule

// File: rtl/yscaler_line_sched.sv
// yscaler_line_sched: line-level scheduler for the vertical
// scaler; tracks line-buffer residency, carries no pixels.
module yscaler_line_sched #(
  parameter int NBUF  = yscaler_pkg::NBUF,
  parameter int DIM_W = yscaler_pkg::DIM_W
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DIM_W-1:0]        ori_height,
  input  logic [DIM_W-1:0]        scale_height,
  input  logic                    in_sof,
  input  logic                    in_eol,
  input  logic                    out_eol,
  output logic                    in_allow,
  output logic [$clog2(NBUF)-1:0] in_wr_sel,
  output logic                    out_allow,
  output logic [$clog2(NBUF)-1:0] out_rd_sel,
  output logic                    out_sof,
  output logic                    frame_done,
  output logic                    cfg_err
);

  import yscaler_pkg::*;

  localparam int CW = DIM_W + 1;
  localparam int SW = $clog2(NBUF);
  localparam logic [CW:0] NB = (CW+1)'(NBUF);

  state_e        state, state_nx;
  logic [CW-1:0] wr_row, out_row, src_row;
  logic [CW-1:0] ori_h, scale_h;
  logic [CW:0]   occ;
  logic          cfg_bad, occ_ok, rows_left;
  logic          adv_busy, dda_add, dda_step;

  assign cfg_bad = (ori_height == '0) ||
                   (scale_height == '0);

  assign dda_add  = (state == RUN) && out_eol && !in_sof;
  assign dda_step = (state == ADVANCE) &&
                    (out_row != scale_h);

  yscaler_dda #(.DIM_W(DIM_W)) u_dda (
    .clk          (clk),
    .rst_n        (resetn),
    .clr          (in_sof),
    .add          (dda_add),
    .step         (dda_step),
    .ori_h        (ori_h),
    .scale_h      (scale_h),
    .src_row      (src_row),
    .advance_busy (adv_busy)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = IDLE;
      RUN:     if (out_eol) state_nx = ADVANCE;
      ADVANCE: begin
        if (out_row == scale_h) state_nx = DRAIN;
        else if (!adv_busy)     state_nx = RUN;
      end
      DRAIN:   if (!rows_left) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (in_sof) state_nx = cfg_bad ? IDLE : RUN;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_row  <= '0;
      out_row <= '0;
      ori_h   <= '0;
      scale_h <= '0;
      cfg_err <= 1'b0;
    end else if (in_sof) begin
      ori_h   <= {1'b0, ori_height};
      scale_h <= {1'b0, scale_height};
      cfg_err <= cfg_bad;
      out_row <= '0;
      // a one-pixel first line completes row 0 on the sof beat
      wr_row  <= (in_eol && !cfg_bad) ? CW'(1) : '0;
    end else begin
      if (in_eol && state != IDLE)
        wr_row <= wr_row + CW'(1);
      if (out_eol && state == RUN)
        out_row <= out_row + CW'(1);
    end
  end

  // signed: after a downscale step src_row may lead wr_row
  assign occ       = {1'b0, wr_row} - {1'b0, src_row};
  assign occ_ok    = $signed(occ) < $signed(NB);
  assign rows_left = (wr_row < ori_h);

  always_comb begin
    in_allow   = 1'b1;
    out_allow  = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: in_allow = 1'b1;
      RUN: begin
        in_allow  = rows_left && occ_ok;
        out_allow = (src_row < wr_row) &&
                    (out_row < scale_h);
      end
      ADVANCE: in_allow = rows_left && occ_ok;
      DRAIN: begin
        in_allow   = rows_left;
        frame_done = !rows_left;
      end
      default: in_allow = 1'b1;
    endcase
  end

  assign out_sof    = (out_row == '0);
  assign in_wr_sel  = wr_row[SW-1:0];
  assign out_rd_sel = src_row[SW-1:0];

endmodule
